flag_sched: RTL

FLAG_SCHED -- requirements
Module: flag_sched

---
 rtl/flag_sched_pkg.sv | 36 +++
 rtl/flag_sched_entry.sv | 21 ++
 rtl/flag_sched.sv | 90 +++++++++
 3 files changed

// File: rtl/flag_sched_pkg.sv
// Shared CPU definitions used by the flag scheduler: opcodes, branch condition
// codes, the flag pipeline entry type and the opcode-to-flag-write-mask decode.
package flag_sched_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;

  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GE  = 3'b100;
  localparam logic [2:0] CC_LE  = 3'b101;
  localparam logic [2:0] CC_OVF = 3'b110;
  localparam logic [2:0] CC_UNC = 3'b111;

  // Flag bit order throughout is {Z,V,N}.
  typedef struct packed {
    logic       valid;
    logic [2:0] mask;
    logic [2:0] flags;
  } entry_t;

  function automatic logic [2:0] decode_mask(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB:                 decode_mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: decode_mask = 3'b100;
      default:                        decode_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/flag_sched_entry.sv
// One registered flag pipeline entry (used for both MEM and WB slots).
module flag_pipe_entry
  import flag_sched_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_load,
  input  entry_t i_d,
  output entry_t o_q
);

  entry_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/flag_sched.sv
// Condition-flag scheduler: tracks in-flight flag writes in MEM/WB, drives the
// flag register write port and resolves ID-stage branch conditions with forwarding.
module flag_sched
  import flag_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  logic [3:0] ex_op,
  input  logic [2:0] ex_flags,
  input  logic       pipe_stall,
  input  logic       pipe_flush,
  input  logic [2:0] flags_q,
  output logic [2:0] flag_wen,
  output logic [2:0] flag_din,
  input  logic       br_valid,
  input  logic [2:0] br_cond,
  output logic       br_ready,
  output logic       br_taken
);

  entry_t     w_mem_d, w_mem_q, w_wb_d, w_wb_q;
  logic [2:0] w_ex_mask, w_eff, w_req;
  logic       w_load, w_cond, w_blocked;

  assign w_ex_mask = decode_mask(ex_op);
  assign w_load    = pipe_flush | ~pipe_stall;

  // A flush squashes EX and demotes the old MEM contents to an invalid WB entry.
  always_comb begin
    w_mem_d = '{valid: ex_valid, mask: w_ex_mask, flags: ex_flags};
    w_wb_d  = w_mem_q;
    if (pipe_flush) begin
      w_mem_d       = w_mem_q;
      w_mem_d.valid = 1'b0;
      w_wb_d.valid  = 1'b0;
    end
  end

  flag_pipe_entry u_mem (
    .clk   (clk),
    .rst_n (rst),
    .i_load(w_load),
    .i_d   (w_mem_d),
    .o_q   (w_mem_q)
  );

  flag_pipe_entry u_wb (
    .clk   (clk),
    .rst_n (rst),
    .i_load(w_load),
    .i_d   (w_wb_d),
    .o_q   (w_wb_q)
  );

  assign flag_wen = (w_wb_q.valid && !pipe_stall) ? w_wb_q.mask : 3'b000;
  assign flag_din = w_wb_q.flags;

  always_comb begin
    w_eff = flags_q;
    for (int i = 0; i < 3; i++) begin
      if (ex_valid && w_ex_mask[i])             w_eff[i] = ex_flags[i];
      else if (w_mem_q.valid && w_mem_q.mask[i]) w_eff[i] = w_mem_q.flags[i];
      else if (w_wb_q.valid && w_wb_q.mask[i])   w_eff[i] = w_wb_q.flags[i];
    end
  end

  // w_eff = {Z,V,N}
  always_comb begin
    w_req  = 3'b000;
    w_cond = 1'b0;
    case (br_cond)
      CC_NE:  begin w_req = 3'b100; w_cond = ~w_eff[2];              end
      CC_EQ:  begin w_req = 3'b100; w_cond =  w_eff[2];              end
      CC_GT:  begin w_req = 3'b101; w_cond = ~w_eff[2] & ~w_eff[0];  end
      CC_LT:  begin w_req = 3'b001; w_cond =  w_eff[0];              end
      CC_GE:  begin w_req = 3'b101; w_cond =  w_eff[2] | ~w_eff[0];  end
      CC_LE:  begin w_req = 3'b101; w_cond =  w_eff[2] |  w_eff[0];  end
      CC_OVF: begin w_req = 3'b010; w_cond =  w_eff[1];              end
      CC_UNC: begin w_req = 3'b000; w_cond = 1'b1;                   end
      default: ;
    endcase
  end

  // EX flags arrive too late to feed a branch, so a dependency on them stalls it.
  assign w_blocked = rst & br_valid & ex_valid & |(w_ex_mask & w_req);
  assign br_ready  = ~w_blocked;
  assign br_taken  = rst & br_valid & ~w_blocked & w_cond;

endmodule
